game_tick_scheduler: RTL
========================

# game_tick_scheduler

Single-clock timing sequencer for the crossy-road game. It replaces divided-clock fan-out with one-cycle enable strobes on `clk`. It runs a start/pause/stop/timeout state machine that gates the game-rate strobes, schedules the car-movement strobe from the difficulty level, and counts down the round timer. It sits between the player-input debouncers and the game-logic, display and scan blocks. The display scan index free-runs regardless of game state.

## Interface
- `BASE_DIV`, 1000000: `clk` cycles per `tick_100` (100 Hz at 100 MHz).
- `SEC_DIV`, 100: `tick_100` strobes per `tick_sec`.
- `SCAN_DIV`, 32768: `clk` cycles per `scan` increment.
- `MOVE_BASE`, 40: `tick_100` strobes per `tick_move` at level 0.
- `MOVE_STEP`, 4: period reduction per level step. `MOVE_BASE - 7*MOVE_STEP` must be at least 1.
- `TIME_LIMIT`, 99: round length in seconds, at most 127.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse; starts or restarts a round.
- `pause`, input, 1: one-cycle pulse; toggles RUN and PAUSE.
- `stop`, input, 1: one-cycle pulse; aborts to IDLE.
- `level`, input, 3: difficulty level, 0 to 7.
- `state`, output, 2: current state; IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `run`, output, 1: high when `state` is RUN.
- `tick_100`, output, 1: 100 Hz strobe, gated by RUN.
- `tick_sec`, output, 1: 1 Hz strobe, gated by RUN.
- `tick_move`, output, 1: car-movement strobe, gated by RUN.
- `scan`, output, 2: free-running display digit index.
- `time_left`, output, 7: seconds remaining in the round.
- `timeout`, output, 1: one-cycle pulse on entry to DONE.

## Operation
- Reset values:
  - `state` is IDLE and `run` is 0.
  - `tick_100`, `tick_sec`, `tick_move`, `timeout` and `scan` are 0.
  - `time_left` is `TIME_LIMIT`.
  - All internal counters are 0; the latched move period is `MOVE_BASE`.
- Input priority within a cycle: `stop` > `start` > `pause`. Lower-priority inputs in the same cycle are ignored.
- State transitions:
  - `stop` from any state goes to IDLE and reloads `time_left` with `TIME_LIMIT`.
  - `start` from any state goes to RUN. It loads `time_left` with `TIME_LIMIT`, clears the base, second and move counters, and latches the move period from `level`.
  - `pause` toggles RUN to PAUSE and PAUSE to RUN. It is ignored in IDLE and DONE.
  - In RUN, a `tick_sec` that takes `time_left` from 1 to 0 moves the state to DONE at the same edge and pulses `timeout`.
  - DONE holds, with `time_left` at 0, until `start` or `stop`.
- Counters:
  - Counters advance at every edge whose preceding cycle was in RUN, unless `start` or `stop` is asserted in that cycle.
  - A `pause` in that cycle does not suppress the advance.
  - Counters hold their values in PAUSE and are cleared in IDLE and DONE.
- Base counter:
  - Counts 0 to `BASE_DIV-1`, then wraps.
  - The wrap edge registers `tick_100` high for one cycle.
- Second counter:
  - Counts base wraps, 0 to `SEC_DIV-1`.
  - On its wrap, `tick_sec` is high in the same cycle as the coincident `tick_100`, and `time_left` decrements at that edge.
- Move counter:
  - Counts base wraps, 0 to P-1, where P = `MOVE_BASE - MOVE_STEP*level`.
  - P is latched at `start` and again at each `tick_move`.
  - A `level` change takes effect only after the next `tick_move`.
  - `tick_move` coincides with the `tick_100` that completes the period.
- Scan counter:
  - Counts 0 to `SCAN_DIV-1` in every state.
  - Each wrap increments `scan` modulo 4.
- Arithmetic: P is computed unsigned at 8 bits. `time_left` never decrements below 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `state` and `run` update at the edge that samples `start`, `stop` or `pause`.
- Call the edge that enters RUN E0. `tick_100` is high in the cycle after edge E(k·`BASE_DIV`), for k ≥ 1, counting RUN edges only.
- `tick_sec` has period `BASE_DIV*SEC_DIV` RUN cycles. `tick_move` has period `BASE_DIV*P` RUN cycles.
- On PAUSE→RUN, the phase resumes exactly; no strobe is lost or duplicated.
- Asserting `rst_n` mid-round immediately forces all reset values, without waiting for a clock edge.

## Test plan
All scenarios use `BASE_DIV`=4, `SEC_DIV`=5, `SCAN_DIV`=8, `MOVE_BASE`=10, `MOVE_STEP`=1, `TIME_LIMIT`=3.
- Reset, then 40 idle cycles:
  - All outputs hold reset values.
  - `scan` steps 0→1→2→3→0 every 8 cycles.
  - No strobes occur.
- `start` with `level`=0:
  - `tick_100` after E4, E8, and so on.
  - `tick_sec` after E20, E40, E60, with `time_left` going 3→2→1→0.
  - `tick_move` after E40.
  - At E60, `state` becomes DONE and `timeout` is high for exactly 1 cycle.
  - No strobes occur afterward.
- `pause` sampled at E10, then 50 idle cycles, then `pause` again at edge P:
  - No strobes and `time_left` is unchanged while paused.
  - The next `tick_100` occurs after edge P+2.
  - `tick_sec` occurs 10 RUN edges later.
- `start` with `level`=3, then `level` changed to 0 after the first `tick_move`:
  - The first `tick_move` occurs after E28.
  - The next occurs 40 cycles later, after E68.
- Priority and reset:
  - `stop` and `start` in the same cycle during RUN give IDLE, `time_left`=3 and no strobes.
  - `pause` in IDLE or DONE is ignored.
  - `rst_n` low mid-RUN gives reset values asynchronously.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
// Single-clock timing sequencer for the crossy-road game. Replaces divided
// clocks with one-cycle enable strobes on clk, runs the start/pause/stop/
// timeout state machine, schedules car movement from the difficulty level
// and counts down the round timer. The display scan index free-runs.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start/pause/stop  one-cycle control pulses (priority stop > start > pause)
//   level[2:0]        difficulty level, sampled at start and at each tick_move
//   state[1:0]        IDLE=0, RUN=1, PAUSE=2, DONE=3
//   run               high while state is RUN
//   tick_100          100 Hz strobe, only generated from RUN cycles
//   tick_sec          1 Hz strobe, coincides with a tick_100
//   tick_move         car-movement strobe, coincides with a tick_100
//   scan[1:0]         free-running display digit index
//   time_left[6:0]    seconds remaining in the round
//   timeout           one-cycle pulse on entry to DONE
module game_tick_scheduler #(
  parameter int BASE_DIV   = 1000000,
  parameter int SEC_DIV    = 100,
  parameter int SCAN_DIV   = 32768,
  parameter int MOVE_BASE  = 40,
  parameter int MOVE_STEP  = 4,
  parameter int TIME_LIMIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [2:0] level,
  output logic [1:0] state,
  output logic       run,
  output logic       tick_100,
  output logic       tick_sec,
  output logic       tick_move,
  output logic [1:0] scan,
  output logic [6:0] time_left,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int SEC_W  = (SEC_DIV  > 1) ? $clog2(SEC_DIV)  : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0]        TL_INIT   = 7'(TIME_LIMIT);

  logic [BASE_W-1:0] base_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [7:0]        move_cnt;
  logic [7:0]        move_period;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        state_next;
  logic [7:0]        level_period;

  logic advance;
  logic base_wrap;
  logic sec_wrap;
  logic move_wrap;
  logic expire;

  // A RUN cycle advances the counters unless start/stop restarts them;
  // a pause sampled in the same cycle still lets this last edge count.
  assign advance   = (state == ST_RUN) && !start && !stop;
  assign base_wrap = advance && (base_cnt == BASE_LAST);
  assign sec_wrap  = base_wrap && (sec_cnt == SEC_LAST);
  assign move_wrap = base_wrap && (move_cnt == move_period - 8'd1);
  assign expire    = sec_wrap && (time_left == 7'd1);

  assign level_period = 8'(MOVE_BASE) - 8'(MOVE_STEP) * {5'd0, level};

  // Expiry outranks a coincident pause so a round cannot freeze at zero.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_RUN;
    end else if (expire) begin
      state_next = ST_DONE;
    end else if (pause && (state == ST_RUN)) begin
      state_next = ST_PAUSE;
    end else if (pause && (state == ST_PAUSE)) begin
      state_next = ST_RUN;
    end
  end

  // The move period is relatched only at start and at each tick_move, so a
  // level change never disturbs a period already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      tick_100    <= 1'b0;
      tick_sec    <= 1'b0;
      tick_move   <= 1'b0;
      timeout     <= 1'b0;
      time_left   <= TL_INIT;
      move_period <= 8'(MOVE_BASE);
    end else begin
      state     <= state_next;
      run       <= (state_next == ST_RUN);
      tick_100  <= base_wrap;
      tick_sec  <= sec_wrap;
      tick_move <= move_wrap;
      timeout   <= expire;
      if (stop || start) begin
        time_left <= TL_INIT;
      end else if (sec_wrap && (time_left != 7'd0)) begin
        time_left <= time_left - 7'd1;
      end
      if ((start && !stop) || move_wrap) begin
        move_period <= level_period;
      end
    end
  end

  // Game-rate counters: advance in RUN, hold in PAUSE, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_cnt <= '0;
      sec_cnt  <= '0;
      move_cnt <= '0;
    end else if (start || stop || (state == ST_IDLE) || (state == ST_DONE)) begin
      base_cnt <= '0;
      sec_cnt  <= '0;
      move_cnt <= '0;
    end else if (advance) begin
      base_cnt <= base_wrap ? '0 : base_cnt + BASE_W'(1);
      if (base_wrap) begin
        sec_cnt  <= sec_wrap  ? '0 : sec_cnt + SEC_W'(1);
        move_cnt <= move_wrap ? '0 : move_cnt + 8'd1;
      end
    end
  end

  // Display scan runs in every state, independent of the game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan     <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan     <= scan + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule
